dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder_array.sv | 23 ++
 rtl/dmem_responder.sv | 94 +++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and error codes for the data-memory responder.
// Also hosts the request classifier used at acceptance.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [1:0] ERR_OK         = 2'b00;
    localparam logic [1:0] ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] ERR_RANGE      = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL    = 2'b11;

    // Priority: illegal command, then alignment, then range.
    function automatic logic [1:0] classify(
        input logic        rd,
        input logic        wr,
        input logic [63:0] addr,
        input int unsigned idx_w
    );
        logic [1:0] err;
        err = ERR_OK;
        if (rd == wr)
            err = ERR_ILLEGAL;
        else if (addr[2:0] != 3'd0)
            err = ERR_MISALIGNED;
        else if ((addr >> (3 + idx_w)) != 64'd0)
            err = ERR_RANGE;
        return err;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between datapath and data memory.
// master = datapath side, slave = memory responder side.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_err;

    modport master (
        output req_valid, req_read, req_write,
        output req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid,
        input  rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_read, req_write,
        input  req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid,
        output rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Word store: synchronous write, asynchronous read, not reset.
// Contents are undefined until written.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Doubleword data-memory responder with fixed response latency.
// One request outstanding; errors never touch storage.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam bit LAT1  = (LATENCY == 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      rdata_q;
    logic [1:0]       err_q;
    logic             accept;
    logic [1:0]       err_in;
    logic             we;
    logic [63:0]      arr_rdata;

    assign accept = (state == IDLE) && bus.req_valid;
    assign err_in = classify(bus.req_read, bus.req_write,
                             bus.req_addr, IDX_W);
    assign we     = accept && (err_in == ERR_OK)
                    && bus.req_write;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .addr (bus.req_addr[3 +: IDX_W]),
        .wdata(bus.req_wdata),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.req_valid)
                      state_nx = LAT1 ? RESP : BUSY;
            BUSY: if (cnt == CNT_W'(1))
                      state_nx = RESP;
            RESP: if (bus.rsp_ready)
                      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state)
            IDLE:    bus.req_ready = 1'b1;
            RESP:    bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Read data is captured at acceptance so the response is fixed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else if (accept) begin
            cnt     <= CNT_W'(LATENCY - 1);
            err_q   <= err_in;
            rdata_q <= (err_in == ERR_OK && bus.req_read)
                       ? arr_rdata : 64'd0;
        end else if (state == BUSY) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule
